onchip_mem_arbiter: RTL
=======================

Name: onchip_mem_arbiter

Overview:
- Shares the single-port on-chip RAM (32-bit data, 16-bit word address, 4 byte lanes, unregistered q, 1-cycle read latency) between two Avalon-MM requesters, m0 and m1.
- m0 is typically the Nios II data master; m1 is typically the signal-path DMA.
- Uses round-robin arbitration with a registered read-response pipeline and out-of-range protection.
- Sits directly between the interconnect and the RAM's address/byteenable/chipselect/write/clken pins.

Parameters:
- DEPTH, 35000: RAM words; addresses >= DEPTH are out of range.
- AW, 16: address width in words.
- DW, 32: data width; byte lanes = DW/8.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_address  in  AW  word address.
- m0_read  in  1  read request.
- m0_write  in  1  write request.
- m0_byteenable  in  DW/8  write byte lanes.
- m0_writedata  in  DW  write data.
- m0_waitrequest  out  1  request not accepted this cycle.
- m0_readdata  out  DW  read data.
- m0_readdatavalid  out  1  read data valid.
- m1_address, m1_read, m1_write, m1_byteenable, m1_writedata, m1_waitrequest, m1_readdata, m1_readdatavalid: identical to the m0_* set.
- freeze  in  1  halts new grants.
- oor_clr  in  1  clears oor_err.
- ram_address  out  AW  to RAM.
- ram_byteenable  out  DW/8  to RAM.
- ram_chipselect  out  1  to RAM.
- ram_write  out  1  to RAM.
- ram_writedata  out  DW  to RAM.
- ram_clken  out  1  RAM clock enable.
- ram_readdata  in  DW  RAM q, valid one cycle after the address cycle.
- oor_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset and state machine:
  - Reset values: state=INIT; rr_last=1, so m0 wins the first conflict; rd_pend=0; oor_err=0; all readdatavalid=0; all ram_* outputs=0.
  - States: INIT -> RUN one cycle after reset_n deasserts.
  - RUN -> FROZEN while freeze=1; FROZEN -> RUN when freeze=0.
  - In INIT and FROZEN: no grants, and mX_waitrequest = mX_read|mX_write.
- Requests:
  - reqX = mX_read|mX_write. If both are asserted, the write is taken and the read is ignored.
- Grant (combinational, RUN only):
  - Only one requester active: that requester is granted.
  - Both active: grant the one != rr_last.
  - rr_last updates to the granted index only on a grant.
  - mX_waitrequest = reqX & ~grantX.
- RAM drive on a grant:
  - ram_chipselect=1; ram_address/byteenable/writedata are muxed from the winner; ram_write = winner write.
  - ram_byteenable is forced to all-ones for reads.
  - Out-of-range grant (address >= DEPTH): chipselect=0 and write suppressed; oor_err is set next cycle.
- ram_clken = 1 except in FROZEN, where it is 0 so the RAM output holds.
- Read pipeline:
  - An accepted read registers rd_pend=1, rd_owner, rd_oor.
  - Next cycle: readdatavalid=1 on rd_owner only.
  - readdata = rd_oor ? 0 : ram_readdata. The non-owner's readdata is 0.
  - Read latency is exactly 1 cycle after acceptance.
  - Back-to-back accepted reads give back-to-back valids.
- Writes complete in their grant cycle and produce no response.
- freeze asserted with rd_pend=1: the pending response is still delivered the next cycle, since clken is gated only after it.
- oor_err stays set until oor_clr=1. If set and clear occur in the same cycle, set wins.
- Reset mid-read: the pending response is discarded and no readdatavalid is issued.
- Address wrap is not performed; out-of-range never aliases.

Optional Feature:
- ONCHIP_MEM_ARB_STATS_EN defined adds three ports:
  - stat_m0_grants  out 32
  - stat_m1_grants  out 32
  - stat_conflicts  out 32 (cycles with both requesting in RUN)
- All three are saturating at 32'hFFFFFFFF, reset to 0, and cleared by oor_clr.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package onchip_mem_arb_pkg holds:
  - state enum {INIT, RUN, FROZEN}
  - requester index typedef
  - DEPTH/AW/DW defaults
  - OOR_READ_DATA constant (0)
- One sub-module: onchip_mem_rr_arb, a 2-way round-robin grant with rr_last register.

Test Plan:
- After reset release, m0 reads address 5 holding 32'hA5A5_0005 -> waitrequest=1 in INIT; accepted next cycle; m0_readdatavalid=1 with 32'hA5A5_0005 one cycle later; m1 stays quiet.
- m0 and m1 write simultaneously and continuously to 10 and 20 -> grants alternate m0,m1,m0,m1; loser waitrequest=1; RAM holds the last writes.
- m1 write 32'h1122_3344 with byteenable 4'b0101 over 0 -> readback 32'h0022_0044.
- m0 reads address 35000 -> readdata 0, readdatavalid=1, oor_err=1 until oor_clr; the RAM is not selected.
- freeze pulsed for 3 cycles during back-to-back m1 reads -> pending valid delivered; no grants during freeze; reads resume with correct data.
- reset_n asserted with rd_pend=1 -> no readdatavalid; all outputs return to reset values.

Source files
------------

// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and defaults for the two-requester on-chip RAM arbiter.
// Optional statistics counters are enabled by defining ONCHIP_MEM_ARB_STATS_EN.
package onchip_mem_arb_pkg;

    localparam int unsigned DEPTH_DEFAULT = 35000;
    localparam int unsigned AW_DEFAULT    = 16;
    localparam int unsigned DW_DEFAULT    = 32;

    localparam logic [31:0] OOR_READ_DATA = '0;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FROZEN} arb_state_e;

    typedef logic req_idx_t;
    localparam req_idx_t REQ_M0 = 1'b0;
    localparam req_idx_t REQ_M1 = 1'b1;

endpackage

// File: rtl/onchip_mem_rr_arb.sv
// Two-way round-robin grant; rr_last remembers the most recent winner.
module onchip_mem_rr_arb
    import onchip_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output req_idx_t   grant_idx
);

    req_idx_t rr_last;

    always_comb begin
        grant = '0;
        if (en) begin
            if (req == 2'b11) begin
                grant = (rr_last == REQ_M1) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    assign grant_idx = grant[1] ? REQ_M1 : REQ_M0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_last <= REQ_M1;
        end else if (|grant) begin
            rr_last <= grant_idx;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port on-chip RAM between two Avalon-MM requesters (m0, m1).
// Define ONCHIP_MEM_ARB_STATS_EN to add saturating grant/conflict counters.
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned DW    = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   m0_address,
    input  logic            m0_read,
    input  logic            m0_write,
    input  logic [DW/8-1:0] m0_byteenable,
    input  logic [DW-1:0]   m0_writedata,
    output logic            m0_waitrequest,
    output logic [DW-1:0]   m0_readdata,
    output logic            m0_readdatavalid,
    input  logic [AW-1:0]   m1_address,
    input  logic            m1_read,
    input  logic            m1_write,
    input  logic [DW/8-1:0] m1_byteenable,
    input  logic [DW-1:0]   m1_writedata,
    output logic            m1_waitrequest,
    output logic [DW-1:0]   m1_readdata,
    output logic            m1_readdatavalid,
    input  logic            freeze,
    input  logic            oor_clr,
    output logic [AW-1:0]   ram_address,
    output logic [DW/8-1:0] ram_byteenable,
    output logic            ram_chipselect,
    output logic            ram_write,
    output logic [DW-1:0]   ram_writedata,
    output logic            ram_clken,
    input  logic [DW-1:0]   ram_readdata,
    output logic            oor_err
`ifdef ONCHIP_MEM_ARB_STATS_EN
    ,
    output logic [31:0]     stat_m0_grants,
    output logic [31:0]     stat_m1_grants,
    output logic [31:0]     stat_conflicts
`endif
);

    arb_state_e state, state_nxt;
    logic       req0, req1;
    logic [1:0] grant;
    req_idx_t   grant_idx;
    logic       any_grant, w_write, w_oor, rd_accept;
    logic [AW-1:0]   w_addr;
    logic [DW/8-1:0] w_be;
    logic [DW-1:0]   w_wdata, rd_data;
    logic       rd_pend, rd_oor;
    req_idx_t   rd_owner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT:   state_nxt = ST_RUN;
            ST_RUN:    if (freeze)  state_nxt = ST_FROZEN;
            ST_FROZEN: if (!freeze) state_nxt = ST_RUN;
            default:   state_nxt = ST_INIT;
        endcase
    end

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    onchip_mem_rr_arb u_rr_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        ((state == ST_RUN) && !freeze),
        .req       ({req1, req0}),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign any_grant      = |grant;
    assign m0_waitrequest = req0 & ~grant[0];
    assign m1_waitrequest = req1 & ~grant[1];

    always_comb begin
        w_addr  = m0_address;
        w_write = m0_write;
        w_be    = m0_byteenable;
        w_wdata = m0_writedata;
        if (grant_idx == REQ_M1) begin
            w_addr  = m1_address;
            w_write = m1_write;
            w_be    = m1_byteenable;
            w_wdata = m1_writedata;
        end
    end

    // Out-of-range accesses are granted (so the requester is not stalled) but never select the RAM.
    assign w_oor     = any_grant && (32'(w_addr) >= DEPTH);
    assign rd_accept = any_grant & ~w_write;

    assign ram_chipselect = any_grant & ~w_oor;
    assign ram_write      = ram_chipselect & w_write;
    assign ram_address    = any_grant ? w_addr : '0;
    assign ram_byteenable = !any_grant ? '0 : (w_write ? w_be : '1);
    assign ram_writedata  = (any_grant && w_write) ? w_wdata : '0;
    assign ram_clken      = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= REQ_M0;
            rd_oor   <= 1'b0;
            oor_err  <= 1'b0;
        end else begin
            rd_pend <= rd_accept;
            if (rd_accept) begin
                rd_owner <= grant_idx;
                rd_oor   <= w_oor;
            end
            if (w_oor)        oor_err <= 1'b1;
            else if (oor_clr) oor_err <= 1'b0;
        end
    end

    assign rd_data          = rd_oor ? DW'(OOR_READ_DATA) : ram_readdata;
    assign m0_readdatavalid = rd_pend && (rd_owner == REQ_M0);
    assign m1_readdatavalid = rd_pend && (rd_owner == REQ_M1);
    assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
    assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

`ifdef ONCHIP_MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_m0_grants <= '0;
            stat_m1_grants <= '0;
            stat_conflicts <= '0;
        end else if (oor_clr) begin
            stat_m0_grants <= '0;
            stat_m1_grants <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant[0] && (stat_m0_grants != '1)) stat_m0_grants <= stat_m0_grants + 32'd1;
            if (grant[1] && (stat_m1_grants != '1)) stat_m1_grants <= stat_m1_grants + 32'd1;
            if ((state == ST_RUN) && req0 && req1 && (stat_conflicts != '1))
                stat_conflicts <= stat_conflicts + 32'd1;
        end
    end
`endif

endmodule
